// File: rtl/bcd_seg_scanner_if.sv
// Valid/ready channel carrying the packed two-digit BCD byte into the scanner.
interface bcd_seg_scanner_if;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (output bcd_in, output bcd_valid, input bcd_ready);
  modport slave  (input bcd_in, input bcd_valid, output bcd_ready);
endinterface

// File: rtl/bcd_seg_scanner.sv
// Double-buffered two-digit BCD to multiplexed active-low 7-segment scanner.
// Optional leading-zero blanking of the tens digit: BCD_SEG_SCANNER_LZ_BLANK_EN.
//
// state  | meaning
// IDLE   | nothing loaded yet, display dark
// SHOW_U | units digit lit on an[0]
// SHOW_T | tens digit lit on an[1]; last cycle is the frame boundary
module bcd_seg_scanner #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  bcd_seg_scanner_if.slave   bcd_if,
  output logic [6:0]         seg,
  output logic [1:0]         an,
  output logic               err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_U = 2'd1,
    SHOW_T = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       pending_q;
  logic             pending_full_q;
  logic [7:0]       display_q;
  logic             err_q;
  logic             accept;
  logic [6:0]       tens_seg;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // The all-ones blank code is deliberate, so it never raises err.
  function automatic logic is_bad(input logic [7:0] v);
    is_bad = (v != 8'hFF) && ((v[7:4] > 4'd9) || (v[3:0] > 4'd9));
  endfunction

  assign bcd_if.bcd_ready = !pending_full_q;
  assign accept           = bcd_if.bcd_valid && !pending_full_q;
  assign err              = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pending_q      <= 8'h00;
      pending_full_q <= 1'b0;
      display_q      <= 8'hFF;
      err_q          <= 1'b0;
    end else begin
      // Accept and transfer are mutually exclusive on pending_full_q.
      if (accept) begin
        pending_q      <= bcd_if.bcd_in;
        pending_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pending_full_q) begin
            display_q      <= pending_q;
            pending_full_q <= 1'b0;
            cnt_q          <= '0;
            state_q        <= SHOW_U;
            if (is_bad(pending_q)) err_q <= 1'b1;
          end
        end
        SHOW_U: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SHOW_T;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHOW_T: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SHOW_U;
            if (pending_full_q) begin
              display_q      <= pending_q;
              pending_full_q <= 1'b0;
              if (is_bad(pending_q)) err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCD_SEG_SCANNER_LZ_BLANK_EN
  assign tens_seg = (display_q[7:4] == 4'd0) ? 7'h7F : decode(display_q[7:4]);
`else
  assign tens_seg = decode(display_q[7:4]);
`endif

  always_comb begin
    seg = 7'h7F;
    an  = 2'b11;
    case (state_q)
      SHOW_U: begin
        an  = 2'b10;
        seg = decode(display_q[3:0]);
      end
      SHOW_T: begin
        an  = 2'b01;
        seg = tens_seg;
      end
      default: begin
        seg = 7'h7F;
        an  = 2'b11;
      end
    endcase
  end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Display stage fed by the 4-bit-to-BCD decoder. Accepts the decoder's packed two-digit BCD byte through a valid/ready handshake and double-buffers it. It time-multiplexes the two digits onto one shared active-low 7-segment bus with per-digit anode enables. New values take effect only at frame boundaries, so a digit pair is never shown half-updated.

## Interface
- REFRESH_DIV, 1000: clock cycles each digit stays lit; legal range ≥ 2; counter width is $clog2(REFRESH_DIV).
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- bcd_in  input  8  packed BCD: [7:4] tens, [3:0] units; 8'hFF is the blank-display code.
- bcd_valid  input  1  bcd_in is valid this cycle.
- bcd_ready  output  1  pending buffer is empty; transfer occurs when bcd_valid && bcd_ready at a clk edge.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  output  2  active-low anodes: an[0] is units, an[1] is tens.
- err  output  1  sticky flag: a non-BCD nibble was displayed.

## Operation
- Registers:
  - pending[7:0] and pending_full.
  - display[7:0].
  - state ∈ {IDLE, SHOW_U, SHOW_T}.
  - cnt.
  - err.
- bcd_ready = !pending_full.
- On an accepting edge: pending ← bcd_in, pending_full ← 1.
- IDLE:
  - seg = 7'h7F, an = 2'b11.
  - If pending_full: display ← pending, pending_full ← 0, cnt ← 0, state ← SHOW_U.
- SHOW_U:
  - an = 2'b10, seg = decode(display[3:0]).
  - When cnt == REFRESH_DIV-1: cnt ← 0, state ← SHOW_T. Otherwise cnt increments.
- SHOW_T:
  - an = 2'b01, seg = decode(display[7:4]).
  - When cnt == REFRESH_DIV-1: cnt ← 0, state ← SHOW_U. This edge is the frame boundary.
  - If pending_full at the frame boundary: display ← pending, pending_full ← 0.
- An accept and a frame-boundary transfer on the same edge cannot collide: accept needs pending_full = 0, and transfer needs pending_full = 1.
- decode, active-low:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - Any nibble >9 → 7F (blank).
- display == 8'hFF: both digits blank, err unaffected.
- Any other display value with a nibble >9: that digit is blank and err ← 1 on the edge display is loaded. err clears only on rst.
- The FSM never returns to IDLE except via rst.

## Timing
- Reset values after any edge with rst = 1:
  - state = IDLE, cnt = 0, pending_full = 0, display = 8'hFF, err = 0.
  - seg = 7'h7F, an = 2'b11, bcd_ready = 1.
- rst overrides everything, including a simultaneous accept or mid-frame scanning; pending data is discarded.
- seg and an are pure decodes of registered state and display, valid in the same cycle as the state.
- First value: accepted at edge E0, loaded into display at E1, units visible from the cycle after E1. Latency from the accepting edge to lit output is one cycle.
- Steady state: a value accepted mid-frame appears at the next SHOW_T→SHOW_U edge. Worst case is 2·REFRESH_DIV cycles.
- bcd_ready drops the cycle after an accept and reasserts the cycle after the frame-boundary transfer. At most one value waits.
- Frame period is exactly 2·REFRESH_DIV cycles. cnt wraps at REFRESH_DIV-1, never at 2^width.

## Configuration
- BCD_SEG_SCANNER_LZ_BLANK_EN:
  - Defined: in SHOW_T, a tens nibble of 0 drives seg = 7'h7F (leading-zero blanking). an timing is unchanged.
  - Undefined: a tens nibble of 0 displays as 7'h40.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset, then 10 idle cycles → seg = 7F, an = 11, bcd_ready = 1, err = 0 every cycle.
- Present bcd_in = 8'h15 with valid for one cycle from IDLE → units lit one cycle after the accepting edge: an = 10, seg = 12 for 4 cycles. Then an = 01, seg = 79 for 4 cycles, repeating.
- While 8'h15 scans, accept 8'h07 mid-SHOW_U, then hold valid with 8'h09:
  - bcd_ready = 0 until the frame boundary.
  - The next frame shows units 78; tens 40, or 7F with the macro defined.
  - 8'h09 is accepted the cycle after ready rises.
- Accept 8'hFF → both digits 7F, err stays 0. Then accept 8'h1C → units 7F, tens 79, err = 1 and stays 1 after 8'h11 is loaded.
- Assert rst for one cycle mid-SHOW_T with pending_full = 1 → next cycle IDLE outputs (7F/11), bcd_ready = 1, err = 0. The old pending value is never displayed.
